// File: rtl/otp_ram_responder_pkg.sv
// rtl/otp_ram_responder_pkg.sv - shared widths, FSM encoding and status layout for the OTP responder
package otp_ram_responder_pkg;

    localparam int BUS_WIDTH  = 32;
    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [BUS_WIDTH-1:0] STATUS_ADDR_DEFAULT = 32'h0000_0FFC;

    // Overflow and lock positions depend on the queue depth and are derived in the top.
    localparam int STATUS_BUSY_BIT  = 0;
    localparam int STATUS_COUNT_LSB = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PROG   = 2'd1,
        ST_COMMIT = 2'd2
    } prog_state_e;

    function automatic logic [DATA_WIDTH-1:0] byte_mask(input logic [STRB_WIDTH-1:0] wen);
        logic [DATA_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            m[8*i +: 8] = {8{wen[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/otp_wq_fifo.sv
// rtl/otp_wq_fifo.sv - synchronous write-queue FIFO; a push while full is accepted only alongside a pop
module otp_wq_fifo #(
    parameter int WIDTH      = 38,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  push,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  pop,
    output logic [WIDTH-1:0]      rdata,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/otp_ram_responder.sv
// rtl/otp_ram_responder.sv - RAM-bus slave modelling set-only OTP cells with a queued multi-cycle program engine
module otp_ram_responder
    import otp_ram_responder_pkg::*;
#(
    parameter int                   DEPTH_LOG2  = 6,
    parameter int                   PROG_CYCLES = 8,
    parameter int                   QDEPTH_LOG2 = 2,
    parameter logic [BUS_WIDTH-1:0] STATUS_ADDR = STATUS_ADDR_DEFAULT
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [BUS_WIDTH-1:0]  s_ram_raddr,
    output logic [DATA_WIDTH-1:0] s_ram_rdata,
    input  logic                  s_ram_ren,
    input  logic [BUS_WIDTH-1:0]  s_ram_waddr,
    input  logic [DATA_WIDTH-1:0] s_ram_wdata,
    input  logic [STRB_WIDTH-1:0] s_ram_wen,
    output logic                  secure_debug_enable
);

    localparam int WORDS    = 1 << DEPTH_LOG2;
    localparam int QCW      = QDEPTH_LOG2 + 1;
    localparam int OVF_BIT  = QDEPTH_LOG2 + 2;
    localparam int LOCK_BIT = QDEPTH_LOG2 + 3;
    localparam int CNT_W    = $clog2(PROG_CYCLES);

    typedef struct packed {
        logic [DEPTH_LOG2-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wq_entry_t;

    logic [DATA_WIDTH-1:0] cells [WORDS];
    prog_state_e           state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic                  lock;
    logic                  overflow;

    logic                  wr_any, wr_status, wr_array, push_acc;
    logic                  q_pop, q_full, q_empty;
    logic [QCW-1:0]        q_count;
    wq_entry_t             q_in, q_head;
    logic [DATA_WIDTH-1:0] status_word;

    assign wr_any    = |s_ram_wen;
    assign wr_status = wr_any && (s_ram_waddr == STATUS_ADDR);
    assign wr_array  = wr_any && !wr_status && !lock;
    assign q_pop     = (state == ST_COMMIT);
    assign push_acc  = wr_array && (!q_full || q_pop);

    assign q_in.addr = s_ram_waddr[DEPTH_LOG2+1:2];
    assign q_in.data = s_ram_wdata & byte_mask(s_ram_wen);

    otp_wq_fifo #(
        .WIDTH      ($bits(wq_entry_t)),
        .DEPTH_LOG2 (QDEPTH_LOG2)
    ) u_wq (
        .clk    (clk),
        .resetn (resetn),
        .push   (wr_array),
        .wdata  (q_in),
        .pop    (q_pop),
        .rdata  (q_head),
        .full   (q_full),
        .empty  (q_empty),
        .count  (q_count)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            lock     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (wr_status && s_ram_wen[0] && s_ram_wdata[0]) lock <= 1'b1;
            if (wr_array && q_full && !q_pop) overflow <= 1'b1;
        end
    end

    // The next word may arrive in the COMMIT cycle itself, so the accepted push keeps the engine running.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            ST_IDLE: begin
                if (!q_empty) begin
                    state_n = ST_PROG;
                    cnt_n   = CNT_W'(PROG_CYCLES - 1);
                end
            end
            ST_PROG: begin
                if (cnt == '0) state_n = ST_COMMIT;
                else           cnt_n   = cnt - CNT_W'(1);
            end
            ST_COMMIT: begin
                if ((q_count > QCW'(1)) || push_acc) begin
                    state_n = ST_PROG;
                    cnt_n   = CNT_W'(PROG_CYCLES - 1);
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < WORDS; i++) cells[i] <= '0;
        end else if (state == ST_COMMIT) begin
            cells[q_head.addr] <= cells[q_head.addr] | q_head.data;
        end
    end

    always_comb begin
        status_word                          = '0;
        status_word[STATUS_BUSY_BIT]         = (state != ST_IDLE);
        status_word[STATUS_COUNT_LSB +: QCW] = q_count;
        status_word[OVF_BIT]                 = overflow;
        status_word[LOCK_BIT]                = lock;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_ram_rdata <= '0;
        end else if (s_ram_ren) begin
            s_ram_rdata <= (s_ram_raddr == STATUS_ADDR) ? status_word
                                                        : cells[s_ram_raddr[DEPTH_LOG2+1:2]];
        end
    end

    assign secure_debug_enable = cells[0][0];

endmodule

// File: tb/tb_otp_ram_responder.sv
// tb/tb_otp_ram_responder.sv - directed self-checking bench for otp_ram_responder
module tb_otp_ram_responder;

    localparam int PC = 8;
    localparam logic [31:0] SADDR = 32'h0000_0FFC;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] s_ram_raddr;
    logic [31:0] s_ram_rdata;
    logic        s_ram_ren;
    logic [31:0] s_ram_waddr;
    logic [31:0] s_ram_wdata;
    logic [3:0]  s_ram_wen;
    logic        secure_debug_enable;

    int total  = 0;
    int passed = 0;

    logic [31:0] sb_exp [$];
    string       sb_tag [$];

    otp_ram_responder dut (
        .clk                 (clk),
        .resetn              (resetn),
        .s_ram_raddr         (s_ram_raddr),
        .s_ram_rdata         (s_ram_rdata),
        .s_ram_ren           (s_ram_ren),
        .s_ram_waddr         (s_ram_waddr),
        .s_ram_wdata         (s_ram_wdata),
        .s_ram_wen           (s_ram_wen),
        .secure_debug_enable (secure_debug_enable)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] wen);
        s_ram_waddr = addr;
        s_ram_wdata = data;
        s_ram_wen   = wen;
        tick();
        s_ram_wen   = 4'h0;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        sb_exp.push_back(exp);
        sb_tag.push_back(tag);
        s_ram_raddr = addr;
        s_ram_ren   = 1'b1;
        tick();
        s_ram_ren   = 1'b0;
        chk(sb_tag.pop_front(), s_ram_rdata, sb_exp.pop_front());
    endtask

    initial begin
        logic [31:0] burst [6];

        resetn      = 1'b0;
        s_ram_raddr = '0;
        s_ram_ren   = 1'b0;
        s_ram_waddr = '0;
        s_ram_wdata = '0;
        s_ram_wen   = 4'h0;
        repeat (3) tick();
        chk("reset_rdata", s_ram_rdata, 32'h0);
        chk("reset_sde", {31'd0, secure_debug_enable}, 32'h0);
        resetn = 1'b1;
        tick();

        rd(32'h14, 32'h0, "rd_word5_reset");
        rd(SADDR, 32'h0, "status_reset");

        // Set-only accumulation and zero writes
        wr(32'h14, 32'h0000_00F0, 4'hF);
        wr(32'h14, 32'h0000_000F, 4'hF);
        repeat (2 * (PC + 1) + 4) tick();
        rd(32'h14, 32'h0000_00FF, "or_accumulate");
        wr(32'h14, 32'h0, 4'hF);
        repeat (PC + 4) tick();
        rd(32'h14, 32'h0000_00FF, "zero_write_noclear");

        // Byte enables and busy flag
        wr(32'h8, 32'hAABB_CCDD, 4'b0101);
        repeat (2) tick();
        rd(SADDR, 32'h3, "status_busy_cnt1");
        repeat (PC + 4) tick();
        rd(SADDR, 32'h0, "status_idle");
        rd(32'h8, 32'h00BB_00DD, "byte_mask");

        // secure_debug_enable timing and read-during-commit
        wr(32'h0, 32'h1, 4'hF);
        tick();
        repeat (PC) tick();
        chk("sde_before_commit", {31'd0, secure_debug_enable}, 32'h0);
        rd(32'h0, 32'h0, "rd_during_commit");
        chk("sde_after_commit", {31'd0, secure_debug_enable}, 32'h1);
        rd(32'h0, 32'h1, "rd_after_commit");

        // Six back-to-back writes: four fit, the last two are dropped
        for (int i = 0; i < 6; i++) burst[i] = 32'h1111_0000 + 32'(i + 1);
        for (int i = 0; i < 6; i++) wr(32'h40 + 32'(4 * i), burst[i], 4'hF);
        rd(SADDR, 32'h19, "status_overflow_full");
        repeat (4) tick();
        rd(32'h40, burst[0], "burst_first_commit");
        rd(32'h44, 32'h0, "burst_second_pending");
        repeat (4 * (PC + 1) + 4) tick();
        for (int i = 0; i < 6; i++)
            rd(32'h40 + 32'(4 * i), (i < 4) ? burst[i] : 32'h0, $sformatf("burst_word%0d", i));
        rd(SADDR, 32'h10, "status_overflow_sticky");

        // Lock
        wr(SADDR, 32'h1, 4'h1);
        wr(32'h20, 32'hFFFF_FFFF, 4'hF);
        rd(SADDR, 32'h30, "status_locked_cnt0");
        repeat (PC + 4) tick();
        rd(32'h20, 32'h0, "locked_write_ignored");

        // Mid-program reset clears everything
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        wr(32'h24, 32'h5, 4'hF);
        repeat (3) tick();
        rd(SADDR, 32'h3, "status_mid_prog");
        #3;
        resetn = 1'b0;
        #1;
        chk("async_reset_sde", {31'd0, secure_debug_enable}, 32'h0);
        chk("async_reset_rdata", s_ram_rdata, 32'h0);
        tick();
        resetn = 1'b1;
        tick();
        rd(SADDR, 32'h0, "status_after_reset");
        repeat (PC + 4) tick();
        rd(32'h24, 32'h0, "abandoned_program");
        rd(32'h14, 32'h0, "array_cleared");
        rd(32'h0, 32'h0, "word0_cleared");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
